// File: rtl/pipeline_control_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// per-cycle action priority, watchdog default and the load-use detector.
package pipeline_control_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FETCH_WAIT = 2'd3
    } state_t;

    // What the controller does this cycle, listed from highest priority down.
    typedef enum logic [2:0] {
        ACT_FREEZE,
        ACT_FLUSH,
        ACT_LOAD_USE,
        ACT_FETCH_BUBBLE,
        ACT_NORMAL
    } action_t;

    localparam int MEM_TIMEOUT_DEFAULT = 255;

    // A load in EX writes a register the ID instruction reads; x0 never hazards.
    function automatic logic load_use_hazard(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2,
        input logic [4:0] rd,
        input logic       mem_read
    );
        return mem_read && (rd != 5'd0) &&
               ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count one per enabled cycle, holding once every bit is set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Five-stage pipeline hazard controller: picks one action per cycle
// (mem freeze > branch flush > load-use stall > fetch bubble > normal),
// drives the pipeline-register controls combinationally, and keeps
// saturating stall/flush counters plus a sticky memory watchdog.
module pipeline_hazard_controller
    import pipeline_control_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    input  logic                 imem_ready,
    output logic                 pc_write,
    output logic                 if_id_stall,
    output logic                 if_id_flush,
    output logic                 id_ex_bubble,
    output logic                 backend_stall,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count,
    output logic                 mem_timeout
);

    // Wait counter only needs to reach MEM_TIMEOUT; one more freeze trips the flag.
    localparam int                    WAIT_WIDTH = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = WAIT_WIDTH'(MEM_TIMEOUT);

    state_t                state_q;
    state_t                state_d;
    action_t               action;
    logic [WAIT_WIDTH-1:0] wait_q;
    logic                  stall_inc;
    logic                  flush_inc;

    assign state = state_q;

    // Pick this cycle's action by strict priority; a held taken branch is
    // naturally flushed once the freeze lifts because EX is still presenting it.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path infers a latch.
        action = ACT_NORMAL;
        if (mem_req && !mem_ready) begin
            action = ACT_FREEZE;
        end else if (ex_branch_taken) begin
            action = ACT_FLUSH;
        end else if ((state_q != LOAD_STALL) &&
                     load_use_hazard(id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
                                     ex_rd, ex_mem_read)) begin
            action = ACT_LOAD_USE;
        end else if (!imem_ready) begin
            action = ACT_FETCH_BUBBLE;
        end
    end

    // Decode the action into pipeline controls and the next state; reset
    // forces a safe front end (flush IF/ID, bubble ID/EX, PC held).
    always_comb begin
        pc_write      = 1'b1;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        backend_stall = 1'b0;
        state_d       = RUN;
        unique case (action)
            ACT_FREEZE: begin
                pc_write      = 1'b0;
                if_id_stall   = 1'b1;
                backend_stall = 1'b1;
                state_d       = MEM_WAIT;
            end
            ACT_FLUSH: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            ACT_LOAD_USE: begin
                pc_write     = 1'b0;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
                state_d      = LOAD_STALL;
            end
            ACT_FETCH_BUBBLE: begin
                pc_write    = 1'b0;
                if_id_flush = 1'b1;
                state_d     = FETCH_WAIT;
            end
            default: ;
        endcase
        if (reset) begin
            pc_write      = 1'b0;
            if_id_stall   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            backend_stall = 1'b0;
        end
    end

    assign stall_inc = (action == ACT_FREEZE) || (action == ACT_LOAD_USE) ||
                       (action == ACT_FETCH_BUBBLE);
    assign flush_inc = (action == ACT_FLUSH);

    // Advance the FSM and track consecutive freeze cycles for the sticky watchdog.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= RUN;
            wait_q      <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            if (action == ACT_FREEZE) begin
                if (wait_q == WAIT_LIMIT) begin
                    mem_timeout <= 1'b1;
                end else begin
                    wait_q <= wait_q + 1'b1;
                end
            end else begin
                wait_q <= '0;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_counter (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_counter (
        .clock (clock),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with narrow counters and a
// short watchdog so saturation and timeout are reachable in a few cycles.
module tb_pipeline_hazard_controller;

    localparam int CW = 4;
    localparam int MT = 4;

    // Control vector order: {pc_write, if_id_stall, if_id_flush, id_ex_bubble, backend_stall}
    localparam logic [4:0] C_NORMAL = 5'b10000;
    localparam logic [4:0] C_FREEZE = 5'b01001;
    localparam logic [4:0] C_FLUSH  = 5'b10110;
    localparam logic [4:0] C_LOAD   = 5'b01010;
    localparam logic [4:0] C_FETCH  = 5'b00100;
    localparam logic [4:0] C_RESET  = 5'b00110;

    logic          clock;
    logic          reset;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic          id_uses_rs1;
    logic          id_uses_rs2;
    logic [4:0]    ex_rd;
    logic          ex_mem_read;
    logic          ex_branch_taken;
    logic          mem_req;
    logic          mem_ready;
    logic          imem_ready;
    logic          pc_write;
    logic          if_id_stall;
    logic          if_id_flush;
    logic          id_ex_bubble;
    logic          backend_stall;
    logic [1:0]    state;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_count;
    logic          mem_timeout;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_controller #(.CNT_WIDTH(CW), .MEM_TIMEOUT(MT)) dut (
        .clock           (clock),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .imem_ready      (imem_ready),
        .pc_write        (pc_write),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .backend_stall   (backend_stall),
        .state           (state),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .mem_timeout     (mem_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic [4:0] exp);
        check(tag, 32'({pc_write, if_id_stall, if_id_flush, id_ex_bubble, backend_stall}), 32'(exp));
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        id_rs1          = 5'd1;
        id_rs2          = 5'd2;
        id_uses_rs1     = 1'b0;
        id_uses_rs2     = 1'b0;
        ex_rd           = 5'd0;
        ex_mem_read     = 1'b0;
        ex_branch_taken = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b1;
        imem_ready      = 1'b1;
    endtask

    task automatic load_use_x5();
        ex_rd       = 5'd5;
        ex_mem_read = 1'b1;
        id_rs1      = 5'd5;
        id_uses_rs1 = 1'b1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        #1;
        check("pulse_stall_cnt", 32'(stall_cycles), 32'd0);
        check("pulse_flush_cnt", 32'(flush_count), 32'd0);
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();

        // Reset values
        check_ctrl("reset_ctrl", C_RESET);
        check("reset_state", 32'(state), 32'd0);
        check("reset_stall_cnt", 32'(stall_cycles), 32'd0);
        check("reset_flush_cnt", 32'(flush_count), 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);

        reset = 1'b0;
        #1;
        check_ctrl("normal_after_reset", C_NORMAL);
        tick();
        check("normal_state", 32'(state), 32'd0);

        // Load-use through rs1: one stall cycle, then hazard ignored in LOAD_STALL
        load_use_x5();
        #1;
        check_ctrl("lu_rs1_ctrl", C_LOAD);
        tick();
        check("lu_rs1_state", 32'(state), 32'd1);
        check("lu_rs1_stall_cnt", 32'(stall_cycles), 32'd1);
        check_ctrl("lu_ignored_in_load_stall", C_NORMAL);
        tick();
        check("lu_back_to_run", 32'(state), 32'd0);
        check("lu_stall_cnt_once", 32'(stall_cycles), 32'd1);

        // rs2 match only counts when rs2 is actually read
        id_rs1      = 5'd7;
        id_rs2      = 5'd5;
        id_uses_rs2 = 1'b0;
        #1;
        check_ctrl("lu_rs2_unused", C_NORMAL);
        id_uses_rs2 = 1'b1;
        #1;
        check_ctrl("lu_rs2_ctrl", C_LOAD);
        tick();
        check("lu_rs2_state", 32'(state), 32'd1);
        check("lu_rs2_stall_cnt", 32'(stall_cycles), 32'd2);
        idle();
        tick();

        // Load to x0 never stalls
        ex_rd       = 5'd0;
        ex_mem_read = 1'b1;
        id_rs1      = 5'd0;
        id_uses_rs1 = 1'b1;
        #1;
        check_ctrl("x0_no_stall", C_NORMAL);
        tick();
        check("x0_state", 32'(state), 32'd0);
        check("x0_stall_cnt", 32'(stall_cycles), 32'd2);

        // Fetch bubble
        idle();
        imem_ready = 1'b0;
        #1;
        check_ctrl("fetch_bubble_ctrl", C_FETCH);
        tick();
        check("fetch_state", 32'(state), 32'd3);
        check("fetch_stall_cnt", 32'(stall_cycles), 32'd3);
        imem_ready = 1'b1;
        #1;
        check_ctrl("fetch_recovered", C_NORMAL);
        tick();
        check("fetch_back_to_run", 32'(state), 32'd0);

        // Branch wins over a simultaneous load-use hazard
        load_use_x5();
        ex_branch_taken = 1'b1;
        #1;
        check_ctrl("flush_over_lu", C_FLUSH);
        tick();
        check("flush_state", 32'(state), 32'd0);
        check("flush_cnt_1", 32'(flush_count), 32'd1);
        check("flush_no_stall_inc", 32'(stall_cycles), 32'd3);

        // Three-cycle memory freeze holding a taken branch, then the flush
        idle();
        reset_pulse();
        mem_req         = 1'b1;
        mem_ready       = 1'b0;
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_ctrl($sformatf("freeze_ctrl_%0d", i), C_FREEZE);
            tick();
            check($sformatf("freeze_state_%0d", i), 32'(state), 32'd2);
        end
        mem_ready = 1'b1;
        #1;
        check_ctrl("held_branch_flush", C_FLUSH);
        tick();
        check("held_flush_state", 32'(state), 32'd0);
        check("held_stall_cnt", 32'(stall_cycles), 32'd3);
        check("held_flush_cnt", 32'(flush_count), 32'd1);
        check("held_no_timeout", 32'(mem_timeout), 32'd0);

        // Watchdog: an interrupted run clears the count, six straight freezes trip it
        idle();
        reset_pulse();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        repeat (4) tick();
        mem_ready = 1'b1;
        tick();
        check("wd_after_break", 32'(mem_timeout), 32'd0);
        mem_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("wd_freeze_%0d", i), 32'(mem_timeout), (i >= 5) ? 32'd1 : 32'd0);
        end
        mem_ready = 1'b1;
        tick();
        check("wd_sticky", 32'(mem_timeout), 32'd1);
        check("wd_stall_cnt", 32'(stall_cycles), 32'd10);
        check("wd_state", 32'(state), 32'd0);

        // Flush counter saturation
        idle();
        reset_pulse();
        ex_branch_taken = 1'b1;
        repeat (15) tick();
        check("flush_cnt_full", 32'(flush_count), 32'hF);
        tick();
        check("flush_cnt_saturated", 32'(flush_count), 32'hF);

        // Stall counter saturation
        idle();
        imem_ready = 1'b0;
        repeat (15) tick();
        check("stall_cnt_full", 32'(stall_cycles), 32'hF);
        tick();
        check("stall_cnt_saturated", 32'(stall_cycles), 32'hF);

        // Reset in the middle of MEM_WAIT aborts immediately
        idle();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        tick();
        check("pre_abort_state", 32'(state), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("abort_state", 32'(state), 32'd0);
        check("abort_stall_cnt", 32'(stall_cycles), 32'd0);
        check("abort_flush_cnt", 32'(flush_count), 32'd0);
        check_ctrl("abort_ctrl", C_RESET);
        tick();
        reset = 1'b0;
        idle();
        tick();

        // Reset during LOAD_STALL: the first cycle after release evaluates from RUN
        load_use_x5();
        tick();
        check("ls_state_before_reset", 32'(state), 32'd1);
        reset = 1'b1;
        #1;
        check("ls_abort_state", 32'(state), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_ctrl("post_reset_from_run", C_LOAD);
        tick();
        check("post_reset_state", 32'(state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
